// File: rtl/mem_port_arbiter_rv_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
// MEM_ARB_BYTE_ENABLE_EN selects byte-enable stores instead of read-modify-write.
package mem_port_arbiter_rv_pkg;

  localparam logic [1:0] MEM_ACCESS_BYTE      = 2'b00;
  localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'b01;
  localparam logic [1:0] MEM_ACCESS_WORD      = 2'b10;

  localparam logic [3:0] EXCEPTION_SUCCESS         = 4'd0;
  localparam logic [3:0] EXCEPTION_MISALIGNED_DATA = 4'd4;

`ifdef MEM_ARB_BYTE_ENABLE_EN
  localparam bit ARB_RMW = 1'b0;
`else
  localparam bit ARB_RMW = 1'b1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I_RD,
    ST_I_WAIT,
    ST_D_RD,
    ST_D_WAIT,
    ST_D_WR,
    ST_RESP
  } arb_state_t;

  function automatic logic misaligned(
    input logic [1:0] acc,
    input logic [1:0] lane
  );
    logic bad;
    bad = 1'b0;
    case (acc)
      MEM_ACCESS_BYTE:      bad = 1'b0;
      MEM_ACCESS_HALF_WORD: bad = lane[0];
      MEM_ACCESS_WORD:      bad = |lane;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_rv.sv
// Little-endian lane handling: load extract/extend and store steering.
// MEM_ARB_BYTE_ENABLE_EN: emit replicated data + lane mask instead of a merged word.
module mem_lane_rv
  import mem_port_arbiter_rv_pkg::*;
(
  input  logic [1:0]  iwAccess,
  input  logic [1:0]  iwLane,
  input  logic        iwSignExtend,
  input  logic [31:0] iwRWord,
  input  logic [31:0] iwWData,
  output logic [31:0] owLoadData,
  output logic [31:0] owStoreData,
  output logic [3:0]  owBe
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_mask;
  logic [31:0] w_repl;
  logic [31:0] w_merge;

  assign w_byte = iwRWord[{iwLane, 3'b000} +: 8];
  assign w_half = iwLane[1] ? iwRWord[31:16] : iwRWord[15:0];

  always_comb begin
    w_mask     = 4'hF;
    w_repl     = iwWData;
    owLoadData = iwRWord;
    case (iwAccess)
      MEM_ACCESS_BYTE: begin
        w_mask     = 4'b0001 << iwLane;
        w_repl     = {4{iwWData[7:0]}};
        owLoadData = {{24{iwSignExtend & w_byte[7]}}, w_byte};
      end
      MEM_ACCESS_HALF_WORD: begin
        w_mask     = iwLane[1] ? 4'b1100 : 4'b0011;
        w_repl     = {2{iwWData[15:0]}};
        owLoadData = {{16{iwSignExtend & w_half[15]}}, w_half};
      end
      default: begin
        w_mask     = 4'hF;
        w_repl     = iwWData;
        owLoadData = iwRWord;
      end
    endcase
  end

  always_comb begin
    w_merge = iwRWord;
    for (int i = 0; i < 4; i++)
      if (w_mask[i])
        w_merge[8*i +: 8] = w_repl[8*i +: 8];
  end

`ifdef MEM_ARB_BYTE_ENABLE_EN
  assign owStoreData = w_repl;
  assign owBe        = w_mask;
`else
  assign owStoreData = w_merge;
  assign owBe        = 4'hF;
`endif

endmodule

// File: rtl/mem_port_arbiter_rv.sv
// Fetch/data arbiter for one single-port SRAM; data has fixed priority.
// MEM_ARB_BYTE_ENABLE_EN: sub-word stores write directly with a lane mask.
module mem_port_arbiter_rv
  import mem_port_arbiter_rv_pkg::*;
#(
  parameter int MEM_ADDR_W = 30
) (
  input  logic                  iwClk,
  input  logic                  iwRst,
  input  logic                  iwIReq,
  input  logic [31:0]           iwIAddr,
  output logic                  orIAck,
  output logic [31:0]           orIData,
  input  logic                  iwDReq,
  input  logic                  iwDWrite,
  input  logic [1:0]            iwDAccess,
  input  logic                  iwDSignExtend,
  input  logic [31:0]           iwDAddr,
  input  logic [31:0]           iwDWData,
  output logic                  orDAck,
  output logic [31:0]           orDRData,
  output logic [3:0]            orDException,
  output logic [MEM_ADDR_W-1:0] orMemAddr,
  output logic                  orMemRead,
  output logic                  orMemWrite,
  output logic [31:0]           orMemWData,
  output logic [3:0]            orMemBe,
  input  logic [31:0]           iwMemRData
);

  arb_state_t r_state, w_next;

  logic        r_isData;
  logic        r_write;
  logic [1:0]  r_access;
  logic        r_sext;
  logic        r_misal;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_dMisal;
  logic        w_direct;
  logic [31:0] w_load;
  logic [31:0] w_store;
  logic [3:0]  w_be;

  assign w_dMisal = misaligned(iwDAccess, iwDAddr[1:0]);
  assign w_direct = iwDWrite & (!ARB_RMW || iwDAccess == MEM_ACCESS_WORD);

  mem_lane_rv u_lane (
    .iwAccess     (r_access),
    .iwLane       (r_addr[1:0]),
    .iwSignExtend (r_sext),
    .iwRWord      (r_rdata),
    .iwWData      (r_wdata),
    .owLoadData   (w_load),
    .owStoreData  (w_store),
    .owBe         (w_be)
  );

  always_ff @(posedge iwClk) begin
    if (iwRst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iwDReq) begin
          if (w_dMisal)      w_next = ST_RESP;
          else if (w_direct) w_next = ST_D_WR;
          else               w_next = ST_D_RD;
        end else if (iwIReq) begin
          w_next = ST_I_RD;
        end
      end
      ST_I_RD:   w_next = ST_I_WAIT;
      ST_I_WAIT: w_next = ST_RESP;
      ST_D_RD:   w_next = ST_D_WAIT;
      ST_D_WAIT: w_next = r_write ? ST_D_WR : ST_RESP;
      ST_D_WR:   w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Requester fields are latched only on acceptance in IDLE.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_isData <= 1'b0;
      r_write  <= 1'b0;
      r_access <= 2'b00;
      r_sext   <= 1'b0;
      r_misal  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (iwDReq) begin
          r_isData <= 1'b1;
          r_write  <= iwDWrite;
          r_access <= iwDAccess;
          r_sext   <= iwDSignExtend;
          r_misal  <= w_dMisal;
          r_addr   <= iwDAddr;
          r_wdata  <= iwDWData;
        end else if (iwIReq) begin
          r_isData <= 1'b0;
          r_write  <= 1'b0;
          r_access <= MEM_ACCESS_WORD;
          r_sext   <= 1'b0;
          r_misal  <= 1'b0;
          r_addr   <= iwIAddr;
          r_wdata  <= '0;
        end
      end
      if (r_state == ST_I_WAIT || r_state == ST_D_WAIT)
        r_rdata <= iwMemRData;
    end
  end

  always_comb begin
    orIAck       = 1'b0;
    orIData      = '0;
    orDAck       = 1'b0;
    orDRData     = '0;
    orDException = EXCEPTION_SUCCESS;
    orMemAddr    = '0;
    orMemRead    = 1'b0;
    orMemWrite   = 1'b0;
    orMemWData   = '0;
    orMemBe      = 4'h0;
    case (r_state)
      ST_I_RD, ST_D_RD: begin
        orMemRead = 1'b1;
        orMemAddr = r_addr[MEM_ADDR_W+1:2];
      end
      ST_D_WR: begin
        orMemWrite = 1'b1;
        orMemAddr  = r_addr[MEM_ADDR_W+1:2];
        orMemWData = w_store;
        orMemBe    = w_be;
      end
      ST_RESP: begin
        if (r_isData) begin
          orDAck       = 1'b1;
          orDException = r_misal ? EXCEPTION_MISALIGNED_DATA
                                 : EXCEPTION_SUCCESS;
          orDRData     = (r_write || r_misal) ? 32'h0 : w_load;
        end else begin
          orIAck  = 1'b1;
          orIData = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter_rv.sv
// Directed-vector bench for mem_port_arbiter_rv with a behavioural SRAM.
// Expectations adapt to MEM_ARB_BYTE_ENABLE_EN.
module tb_mem_port_arbiter_rv;

  localparam logic [1:0] AB = 2'b00;
  localparam logic [1:0] AH = 2'b01;
  localparam logic [1:0] AW = 2'b10;
  localparam logic [3:0] EOK = 4'd0;
  localparam logic [3:0] EMIS = 4'd4;
`ifdef MEM_ARB_BYTE_ENABLE_EN
  localparam int SUB_CYC = 2;
  localparam int SUB_RD  = 0;
`else
  localparam int SUB_CYC = 4;
  localparam int SUB_RD  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iack;
  logic [31:0] idata;
  logic        dreq;
  logic        dwr;
  logic [1:0]  dacc;
  logic        dsext;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;
  logic [3:0]  dexc;
  logic [29:0] maddr;
  logic        mrd;
  logic        mwr;
  logic [31:0] mwdata;
  logic [3:0]  mbe;
  logic [31:0] mrdata;

  always #5 clk = ~clk;

  mem_port_arbiter_rv #(.MEM_ADDR_W(30)) dut (
    .iwClk(clk), .iwRst(rst),
    .iwIReq(ireq), .iwIAddr(iaddr), .orIAck(iack), .orIData(idata),
    .iwDReq(dreq), .iwDWrite(dwr), .iwDAccess(dacc),
    .iwDSignExtend(dsext), .iwDAddr(daddr), .iwDWData(dwdata),
    .orDAck(dack), .orDRData(drdata), .orDException(dexc),
    .orMemAddr(maddr), .orMemRead(mrd), .orMemWrite(mwr),
    .orMemWData(mwdata), .orMemBe(mbe), .iwMemRData(mrdata)
  );

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (mwr)
      for (int i = 0; i < 4; i++)
        if (mbe[i]) mem[maddr[9:0]][8*i +: 8] <= mwdata[8*i +: 8];
    if (mrd) mrdata <= mem[maddr[9:0]];
  end

  int n_rd, n_wr, n_overlap, n_badaddr, n_iack, n_dack;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  always @(negedge clk) begin
    if (mrd) n_rd++;
    if (mwr) begin
      n_wr++;
      last_wdata = mwdata;
      last_be    = mbe;
    end
    if (mrd && mwr) n_overlap++;
    if ((mrd || mwr) && maddr[29:10] != 20'h0) n_badaddr++;
    if (iack) n_iack++;
    if (dack) n_dack++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [3:0]  exp_exc;
    int          exp_cyc;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  task automatic run_req(input vec_t v, output int cyc,
                         output logic [31:0] data, output logic [3:0] exc);
    bit got;
    @(posedge clk); #1;
    if (v.is_d) begin
      dreq = 1'b1; dwr = v.wr; dacc = v.acc; dsext = v.sext;
      daddr = v.addr; dwdata = v.wdata;
    end else begin
      ireq = 1'b1; iaddr = v.addr;
    end
    @(posedge clk);
    n_rd = 0; n_wr = 0;
    cyc = 1; got = 1'b0; data = '0; exc = '0;
    while (!got && cyc <= 12) begin
      @(negedge clk);
      if (v.is_d ? dack : iack) begin
        got = 1'b1;
        data = v.is_d ? drdata : idata;
        exc = dexc;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!got) cyc = -1;
    @(posedge clk); #1;
    dreq = 1'b0; ireq = 1'b0;
  endtask

  vec_t vt [];
  int          cyc;
  logic [31:0] data;
  logic [3:0]  exc;
  int          dcyc, icyc;
  logic [31:0] dd, id;

  function automatic vec_t mk(logic is_d, logic wr, logic [1:0] acc,
      logic sext, logic [31:0] addr, logic [31:0] wd, logic [31:0] ed,
      logic [3:0] ee, int ec, int er, int ew);
    vec_t v;
    v.is_d = is_d; v.wr = wr; v.acc = acc; v.sext = sext; v.addr = addr;
    v.wdata = wd; v.exp_data = ed; v.exp_exc = ee; v.exp_cyc = ec;
    v.exp_rd = er; v.exp_wr = ew;
    return v;
  endfunction

  initial begin
    rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwr = 1'b0;
    dacc = AW; dsext = 1'b0; daddr = '0; dwdata = '0;
    n_overlap = 0; n_badaddr = 0; n_iack = 0; n_dack = 0;

    vt = new[22];
    vt[0]  = mk(1, 1, AW, 0, 32'h000, 32'h0000_0000, 0, EOK, 2, 0, 1);
    vt[1]  = mk(1, 1, AW, 0, 32'h004, 32'hDEAD_BEEF, 0, EOK, 2, 0, 1);
    vt[2]  = mk(1, 1, AW, 0, 32'h040, 32'h8000_7F01, 0, EOK, 2, 0, 1);
    vt[3]  = mk(1, 1, AW, 0, 32'h100, 32'hAABB_CCDD, 0, EOK, 2, 0, 1);
    vt[4]  = mk(1, 1, AW, 0, 32'h200, 32'h11F2_3344, 0, EOK, 2, 0, 1);
    vt[5]  = mk(0, 0, AW, 0, 32'h203, 0, 32'h11F2_3344, EOK, 3, 1, 0);
    vt[6]  = mk(1, 0, AB, 1, 32'h202, 0, 32'hFFFF_FFF2, EOK, 3, 1, 0);
    vt[7]  = mk(1, 0, AB, 0, 32'h202, 0, 32'h0000_00F2, EOK, 3, 1, 0);
    vt[8]  = mk(1, 0, AH, 1, 32'h202, 0, 32'h0000_11F2, EOK, 3, 1, 0);
    vt[9]  = mk(1, 0, AH, 1, 32'h040, 0, 32'h0000_7F01, EOK, 3, 1, 0);
    vt[10] = mk(1, 0, AH, 1, 32'h042, 0, 32'hFFFF_8000, EOK, 3, 1, 0);
    vt[11] = mk(1, 0, AH, 0, 32'h042, 0, 32'h0000_8000, EOK, 3, 1, 0);
    vt[12] = mk(1, 0, AW, 0, 32'h040, 0, 32'h8000_7F01, EOK, 3, 1, 0);
    vt[13] = mk(1, 1, AH, 0, 32'h102, 32'h0000_1234, 0, EOK,
                SUB_CYC, SUB_RD, 1);
    vt[14] = mk(1, 0, AW, 0, 32'h100, 0, 32'h1234_CCDD, EOK, 3, 1, 0);
    vt[15] = mk(1, 1, AB, 0, 32'h003, 32'hFFFF_FF5A, 0, EOK,
                SUB_CYC, SUB_RD, 1);
    vt[16] = mk(1, 0, AW, 0, 32'h000, 0, 32'h5A00_0000, EOK, 3, 1, 0);
    vt[17] = mk(1, 0, AW, 0, 32'h006, 0, 0, EMIS, 1, 0, 0);
    vt[18] = mk(1, 1, AH, 0, 32'h101, 32'h0000_FFFF, 0, EMIS, 1, 0, 0);
    vt[19] = mk(1, 0, 2'b11, 0, 32'h000, 0, 0, EMIS, 1, 0, 0);
    vt[20] = mk(1, 0, AW, 0, 32'h100, 0, 32'h1234_CCDD, EOK, 3, 1, 0);
    vt[21] = mk(1, 0, AB, 1, 32'h103, 0, 32'h0000_0012, EOK, 3, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {27'h0, iack, dack, mrd, mwr, 1'b0}, 32'h0);
    check("reset_data", idata | drdata | mwdata, 32'h0);
    check("reset_addr_be_exc", {maddr[27:0], mbe | dexc}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 22; k++) begin
      run_req(vt[k], cyc, data, exc);
      check($sformatf("v%0d_data", k), data, vt[k].exp_data);
      check($sformatf("v%0d_exc", k), {28'h0, exc}, {28'h0, vt[k].exp_exc});
      check($sformatf("v%0d_cyc", k), cyc, vt[k].exp_cyc);
      check($sformatf("v%0d_rd", k), n_rd, vt[k].exp_rd);
      check($sformatf("v%0d_wr", k), n_wr, vt[k].exp_wr);
    end

    // byte store lane steering, as seen on the SRAM port
    run_req(mk(1, 1, AB, 0, 32'h003, 32'h0000_005A, 0, EOK, 0, 0, 0),
            cyc, data, exc);
    check("bst_cyc", cyc, SUB_CYC);
`ifdef MEM_ARB_BYTE_ENABLE_EN
    check("bst_be", {28'h0, last_be}, 32'h8);
`else
    check("bst_be", {28'h0, last_be}, 32'hF);
`endif
    check("bst_wdata_hi", {24'h0, last_wdata[31:24]}, 32'h5A);

    // simultaneous requests: data wins, fetch follows
    @(posedge clk); #1;
    dreq = 1'b1; dwr = 1'b0; dacc = AW; dsext = 1'b0; daddr = 32'h004;
    ireq = 1'b1; iaddr = 32'h200;
    @(posedge clk);
    dcyc = -1; icyc = -1; dd = '0; id = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (dack) begin dcyc = c; dd = drdata; end
      if (iack) begin icyc = c; id = idata; end
      @(posedge clk); #1;
      if (dcyc == c) dreq = 1'b0;
      if (icyc == c) ireq = 1'b0;
    end
    dreq = 1'b0; ireq = 1'b0;
    check("sim_dcyc", dcyc, 3);
    check("sim_ddata", dd, 32'hDEAD_BEEF);
    check("sim_icyc", icyc, 7);
    check("sim_idata", id, 32'h11F2_3344);

    // reset during D_WAIT aborts the load
    n_iack = 0; n_dack = 0;
    @(posedge clk); #1;
    dreq = 1'b1; dwr = 1'b0; dacc = AW; daddr = 32'h200;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; dreq = 1'b0;
    @(negedge clk);
    check("rst_in_dwait_rd", {31'h0, mrd}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", {26'h0, iack, dack, mrd, mwr, |mbe, |dexc}, 32'h0);
    check("rst_outdata", idata | drdata | mwdata | {2'b00, maddr}, 32'h0);
    repeat (4) @(posedge clk);
    check("rst_noack", n_iack + n_dack, 0);
    run_req(mk(0, 0, AW, 0, 32'h200, 0, 0, EOK, 0, 0, 0), cyc, data, exc);
    check("post_rst_cyc", cyc, 3);
    check("post_rst_data", data, 32'h11F2_3344);

    check("strobe_overlap", n_overlap, 0);
    check("strobe_addr_range", n_badaddr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
